serial_dac_adc_responder: RTL and testbench
===========================================

Name: serial_dac_adc_responder

Overview:
Device-side end of the 3-wire serial DAC/ADC link (SCK, CSLD, SDIN in; SDOUT out). The FPGA's serial master drives this link. The block receives 16-bit MSB-first DAC load frames and returns a 10-bit ADC sample on SDOUT in the same frame. It is used as an on-chip loopback/emulation target for the master side, and as the front end of a soft DAC model.

Parameters:
FRAME_BITS, 16, bits per CSLD-low frame
DATA_BITS, 10, DAC/ADC sample width
DATA_LSB, 2, frame bit index of DAC data LSB (data = frame[DATA_LSB+DATA_BITS-1:DATA_LSB])
SYNC_STAGES, 2, synchronizer depth on SCK, CSLD, SDIN

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
SCK  in  1  serial clock from master, asynchronous to CLK
CSLD  in  1  active-low frame select/load strobe
SDIN  in  1  serial data from master
ADC_DATA  in  DATA_BITS  sample to return, captured at frame start
SDOUT  out  1  serial data to master
DAC_OUT  out  DATA_BITS  last valid DAC data word
DAC_CMD  out  4  last valid command nibble, frame[15:12]
DAC_VALID  out  1  one-CLK pulse when DAC_OUT/DAC_CMD update
FRAME_ERR  out  1  one-CLK pulse on a frame with wrong bit count

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; shift registers 0. Reset mid-frame aborts the frame with no DAC_VALID and no FRAME_ERR.
- Input conditioning: SCK, CSLD and SDIN each pass through SYNC_STAGES flops. Edge detection compares the synchronized value with a 1-cycle delayed copy. Required SCK high/low time is at least 3 CLK.
- States:
  - IDLE: wait for CSLD fall.
  - SHIFT: receive/transmit bits.
  - IDLE is re-entered on CSLD rise.
- CSLD fall (IDLE->SHIFT):
  - bit_cnt <= 0.
  - tx_sr <= ADC_DATA.
  - SDOUT <= 0 (leading null bit).
- SCK rising edge in SHIFT:
  - rx_sr <= {rx_sr[FRAME_BITS-2:0], SDIN_sync}.
  - bit_cnt increments, saturating at FRAME_BITS+1.
- SCK falling edge in SHIFT:
  - falls 1..DATA_BITS: SDOUT <= tx_sr MSB, tx_sr shifts left.
  - later falls: SDOUT <= 0.
- CSLD rise (SHIFT->IDLE):
  - If bit_cnt == FRAME_BITS: DAC_OUT <= data field, DAC_CMD <= rx_sr[15:12], DAC_VALID = 1 for one cycle.
  - Otherwise FRAME_ERR = 1 for one cycle and DAC_OUT/DAC_CMD hold.
  - SDOUT <= 0.
- Latency: DAC_VALID is high SYNC_STAGES+1 CLK cycles after the CSLD pin rises.
- Simultaneous events: if an SCK edge and a CSLD rise are detected in the same cycle, the CSLD rise wins and the SCK edge is ignored. An SCK edge while in IDLE is ignored.
- CSLD glitch: a CSLD rise with bit_cnt == 0 gives FRAME_ERR.
- DAC_VALID and FRAME_ERR are mutually exclusive.
- ADC_DATA changes during SHIFT do not affect the frame in progress.

Decomposition:
- Shared package holds:
  - FRAME_BITS, DATA_BITS, DATA_LSB defaults;
  - state encoding (IDLE=1'b0, SHIFT=1'b1);
  - command nibble constants (CMD_LOAD=4'hF, CMD_NOP=4'h0).
- One sub-module, sync_edge_det: SYNC_STAGES-deep synchronizer with rise/fall pulse outputs and a level output, reset to a parameterized idle level (SCK 0, CSLD 1). It is instantiated for SCK and CSLD; SDIN uses the level output only.

Test Plan:
1. Frame 16'hFFFC (cmd F, data 3FF), SCK period 16 CLK -> DAC_VALID pulse once; DAC_OUT=10'h3FF; DAC_CMD=4'hF; FRAME_ERR=0.
2. Frame 16'h1800 with ADC_DATA=10'h2A5 -> DAC_OUT=10'h200, DAC_CMD=4'h1. Master samples SDOUT on SCK rise as 0, 1,0,1,0,1,0,0,1,0,1, then 0 for the remaining 5 bits.
3. Frame of only 15 SCK pulses, then a frame of 17 -> FRAME_ERR pulses twice; DAC_OUT keeps its previous value 10'h200; DAC_VALID never asserts.
4. RST_N low after bit 8 of a 16'hFFFC frame, released before CSLD rises -> all outputs 0; no DAC_VALID. The next full frame 16'h0004 gives DAC_OUT=10'h001.
5. ADC_DATA changes from 10'h3FF to 10'h000 mid-frame -> SDOUT still returns 3FF bits; the next frame returns all zeros.
6. CSLD rise in the same CLK as the 16th SCK rise (after synchronization) -> rise ignored, bit_cnt=15, FRAME_ERR asserted.

Source files
------------

// File: rtl/serial_dac_adc_responder_pkg.sv
// Shared defaults, state encoding and command nibbles for the serial DAC/ADC responder.
package serial_dac_adc_responder_pkg;
  localparam int DEF_FRAME_BITS  = 16;
  localparam int DEF_DATA_BITS   = 10;
  localparam int DEF_DATA_LSB    = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] CMD_LOAD = 4'hF;
  localparam logic [3:0] CMD_NOP  = 4'h0;
endpackage

// File: rtl/serial_dac_adc_responder_sync_edge_det.sv
// Multi-flop synchronizer with a level output and single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              dly;
  logic [STAGES:0]   vld_pipe;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync     <= {STAGES{IDLE_LVL}};
      dly      <= IDLE_LVL;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[STAGES-2:0], d};
      dly      <= lvl;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  // Edges are masked until the chain holds real pin samples, so a pin that
  // differs from IDLE_LVL at reset release does not look like an edge.
  assign lvl  = sync[STAGES-1];
  assign rise = vld_pipe[STAGES] &  lvl & ~dly;
  assign fall = vld_pipe[STAGES] & ~lvl &  dly;
endmodule

// File: rtl/serial_dac_adc_responder.sv
// Device side of the 3-wire DAC/ADC link: latches DAC load frames, returns an ADC sample.
module serial_dac_adc_responder
  import serial_dac_adc_responder_pkg::*;
#(
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int DATA_LSB    = DEF_DATA_LSB,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SCK,
  input  logic                 CSLD,
  input  logic                 SDIN,
  input  logic [DATA_BITS-1:0] ADC_DATA,
  output logic                 SDOUT,
  output logic [DATA_BITS-1:0] DAC_OUT,
  output logic [3:0]           DAC_CMD,
  output logic                 DAC_VALID,
  output logic                 FRAME_ERR
);
  localparam int CW = $clog2(FRAME_BITS + 2);

  logic sck_lvl, sck_rise, sck_fall;
  logic csld_lvl, csld_rise, csld_fall;
  logic sdin_lvl, sdin_rise_unused, sdin_fall_unused;
  logic unused_ok;

  state_t                state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sck (
    .CLK(CLK), .RST_N(RST_N), .d(SCK),
    .lvl(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_csld (
    .CLK(CLK), .RST_N(RST_N), .d(CSLD),
    .lvl(csld_lvl), .rise(csld_rise), .fall(csld_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sdin (
    .CLK(CLK), .RST_N(RST_N), .d(SDIN),
    .lvl(sdin_lvl), .rise(sdin_rise_unused), .fall(sdin_fall_unused)
  );

  assign unused_ok = &{1'b0, sck_lvl, csld_lvl, sdin_rise_unused, sdin_fall_unused, rx_sr};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      SDOUT     <= 1'b0;
      DAC_OUT   <= '0;
      DAC_CMD   <= '0;
      DAC_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      DAC_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        IDLE: if (csld_fall) begin
          state   <= SHIFT;
          bit_cnt <= '0;
          tx_sr   <= ADC_DATA;
          SDOUT   <= 1'b0;
        end
        SHIFT: begin
          // CSLD rise takes priority over any SCK edge in the same cycle.
          if (csld_rise) begin
            state <= IDLE;
            SDOUT <= 1'b0;
            if (bit_cnt == CW'(FRAME_BITS)) begin
              DAC_OUT   <= rx_sr[DATA_LSB+DATA_BITS-1:DATA_LSB];
              DAC_CMD   <= rx_sr[FRAME_BITS-1 -: 4];
              DAC_VALID <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
          end else if (sck_rise) begin
            rx_sr <= {rx_sr[FRAME_BITS-2:0], sdin_lvl};
            if (bit_cnt != CW'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + 1'b1;
          end else if (sck_fall) begin
            // bit_cnt equals the index of this fall since SCK idles low.
            if (bit_cnt != '0 && bit_cnt <= CW'(DATA_BITS)) begin
              SDOUT <= tx_sr[DATA_BITS-1];
              tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
            end else begin
              SDOUT <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_dac_adc_responder.sv
// Scoreboard bench: stimulus pushes expected DAC events / SDOUT bits, monitors pop and compare.
module tb_serial_dac_adc_responder;
  import serial_dac_adc_responder_pkg::*;

  logic       CLK = 1'b0, RST_N = 1'b0, SCK = 1'b0, CSLD = 1'b1, SDIN = 1'b0;
  logic [9:0] ADC_DATA = '0;
  logic       SDOUT, DAC_VALID, FRAME_ERR;
  logic [9:0] DAC_OUT;
  logic [3:0] DAC_CMD;

  int checks = 0, failures = 0;

  typedef struct {logic err; logic [9:0] dout; logic [3:0] cmd;} evt_t;
  evt_t sb_q[$];
  logic sd_q[$];

  serial_dac_adc_responder dut (
    .CLK(CLK), .RST_N(RST_N), .SCK(SCK), .CSLD(CSLD), .SDIN(SDIN),
    .ADC_DATA(ADC_DATA), .SDOUT(SDOUT), .DAC_OUT(DAC_OUT), .DAC_CMD(DAC_CMD),
    .DAC_VALID(DAC_VALID), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_evt(input logic err, input logic [9:0] d, input logic [3:0] c);
    evt_t e;
    e.err = err; e.dout = d; e.cmd = c;
    sb_q.push_back(e);
  endtask

  task automatic expect_sdout(input logic [15:0] bits);
    for (int i = 0; i < 16; i++) sd_q.push_back(bits[15-i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 60) begin clks(1); n++; end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [15:0] w, input int nbits, input bit merge_last,
                            input int chg_at, input logic [9:0] chg_val);
    CSLD = 1'b0; clks(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) ADC_DATA = chg_val;
      SDIN = (i < 16) ? w[15-i] : 1'b0;
      clks(8);
      if (merge_last && i == nbits - 1) begin
        SCK = 1'b1; CSLD = 1'b1; clks(8);
        SCK = 1'b0; clks(8);
        return;
      end
      SCK = 1'b1; clks(8);
      SCK = 1'b0;
    end
    clks(8); CSLD = 1'b1; clks(8);
  endtask

  // DAC event monitor
  always @(negedge CLK) begin
    if (RST_N && (DAC_VALID || FRAME_ERR)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_evt", 32'({DAC_VALID, FRAME_ERR}), 32'd0);
      end else begin
        evt_t e;
        e = sb_q.pop_front();
        chk("evt_kind", 32'({DAC_VALID, FRAME_ERR}), e.err ? 32'd1 : 32'd2);
        chk("dac_out", 32'(DAC_OUT), 32'(e.dout));
        chk("dac_cmd", 32'(DAC_CMD), 32'(e.cmd));
      end
    end
  end

  // SDOUT monitor: master samples on SCK rise
  always @(posedge SCK) begin
    if (sd_q.size() != 0) begin
      logic b;
      b = sd_q.pop_front();
      chk("sdout_bit", 32'(SDOUT), 32'(b));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clks(3);
    chk("rst_sdout", 32'(SDOUT), 32'd0);
    chk("rst_dac_out", 32'(DAC_OUT), 32'd0);
    chk("rst_dac_cmd", 32'(DAC_CMD), 32'd0);
    chk("rst_pulses", 32'({DAC_VALID, FRAME_ERR}), 32'd0);
    RST_N = 1'b1; clks(6);

    // 1: full load frame
    expect_evt(1'b0, 10'h3FF, CMD_LOAD);
    send_frame(16'hFFFC, 16, 1'b0, -1, '0);
    drain("t1_drain");

    // 2: ADC readback 2A5 -> 0,1010100101,00000
    ADC_DATA = 10'h2A5;
    expect_sdout(16'h54A0);
    expect_evt(1'b0, 10'h200, 4'h1);
    send_frame(16'h1800, 16, 1'b0, -1, '0);
    drain("t2_drain");
    chk("t2_sd_left", 32'(sd_q.size()), 32'd0);

    // 3: short and long frames
    expect_evt(1'b1, 10'h200, 4'h1);
    send_frame(16'hFFFC, 15, 1'b0, -1, '0);
    expect_evt(1'b1, 10'h200, 4'h1);
    send_frame(16'hFFFC, 17, 1'b0, -1, '0);
    drain("t3_drain");
    chk("t3_hold", 32'(DAC_OUT), 32'h200);

    // 4: reset after bit 8
    CSLD = 1'b0; clks(8);
    for (int i = 0; i < 8; i++) begin
      SDIN = 1'b1; clks(8); SCK = 1'b1; clks(8); SCK = 1'b0;
    end
    clks(4);
    RST_N = 1'b0; clks(2);
    chk("t4_rst_dac_out", 32'(DAC_OUT), 32'd0);
    chk("t4_rst_dac_cmd", 32'(DAC_CMD), 32'd0);
    chk("t4_rst_sdout", 32'(SDOUT), 32'd0);
    RST_N = 1'b1; clks(8);
    CSLD = 1'b1; clks(20);
    drain("t4_abort");
    expect_evt(1'b0, 10'h001, CMD_NOP);
    send_frame(16'h0004, 16, 1'b0, -1, '0);
    drain("t4_drain");

    // 5: ADC change mid-frame, then all-zero readback
    ADC_DATA = 10'h3FF;
    expect_sdout(16'h7FE0);
    expect_evt(1'b0, 10'h3FF, CMD_LOAD);
    send_frame(16'hFFFC, 16, 1'b0, 4, 10'h000);
    expect_sdout(16'h0000);
    expect_evt(1'b0, 10'h001, CMD_NOP);
    send_frame(16'h0004, 16, 1'b0, -1, '0);
    drain("t5_drain");
    chk("t5_sd_left", 32'(sd_q.size()), 32'd0);

    // 6: CSLD rise coincides with 16th SCK rise
    expect_evt(1'b1, 10'h001, CMD_NOP);
    send_frame(16'hFFFC, 16, 1'b1, -1, '0);
    drain("t6_drain");
    chk("t6_hold", 32'(DAC_OUT), 32'h001);

    clks(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
